uart_tx_queue: RTL and testbench



---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 37 +++
 rtl/uart_tx_queue.sv | 61 ++++++
 tb/tb_uart_tx_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, sizing helper and line-rate constants for the UART TX/RX pair.
package uart_pkg;
  localparam int CLK_HZ = 2_500_000;
  localparam int BAUD   = 115_200;
  typedef enum logic [1:0] {S_IDLE, S_ISSUED, S_WAIT} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through circular buffer; pointer MSB disambiguates full from empty.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;
  assign empty    = wr_ptr_q == rd_ptr_q;
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  always_ff @(posedge clk) begin
    wr_ptr_q <= !rst_n ? '0 : wr_ptr_d;
    rd_ptr_q <= !rst_n ? '0 : rd_ptr_d;
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffers bytes and issues them to the serial transmitter over start/data/busy.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data
);
  state_e state_q, state_d;
  logic tx_start_q, tx_start_d, overflow_q, overflow_d, pop;
  logic [7:0] tx_data_q, tx_data_d, head;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(wr_en), .pop(pop), .wr_data(wr_data),
    .rd_data(head), .full(full), .empty(empty), .count(count)
  );
  // ISSUED spends one cycle so the transmitter's delayed busy rise is seen before WAIT tests it
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (wr_en & full);
    case (state_q)
      S_IDLE: if (!empty && !tx_busy) begin
        pop        = 1'b1;
        tx_start_d = 1'b1;
        tx_data_d  = head;
        state_d    = S_ISSUED;
      end
      S_ISSUED: state_d = S_WAIT;
      S_WAIT:   state_d = tx_busy ? S_WAIT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed bench with a small transmitter model (1 start, 8 data, 2 stop bits).
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int BIT = 4;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, ext_busy = 1'b0;
  logic [7:0] wr_data = 8'h00, tx_data;
  logic tx_busy, tx_start, full, empty, overflow, txd;
  logic [4:0] count;
  int checks = 0, errors = 0;
  logic model_busy = 1'b0;
  logic [10:0] sh = '1;
  int bit_cnt = 0, div = 0;
  logic [7:0] log_q[$];
  int gaps[$];
  int cyc = 0, fall_edge = 0, busy_err = 0, consec_err = 0;
  logic busy_s = 1'b0, start_prev = 1'b0;
  logic [10:0] frame;

  always #5 clk = ~clk;
  assign tx_busy = model_busy | ext_busy;
  assign txd = model_busy ? sh[0] : 1'b1;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data)
  );

  // transmitter: busy rises one cycle after it sees the start pulse, no reset
  always @(posedge clk) begin
    if (!model_busy && tx_start) begin
      sh <= {2'b11, tx_data, 1'b0};
      model_busy <= 1'b1;
      bit_cnt <= 0;
      div <= 0;
    end else if (model_busy) begin
      if (div == BIT - 1) begin
        div <= 0;
        sh <= {1'b1, sh[10:1]};
        if (bit_cnt == 10) model_busy <= 1'b0;
        else bit_cnt <= bit_cnt + 1;
      end else div <= div + 1;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (busy_s && !tx_busy) fall_edge = cyc;
    busy_s = tx_busy;
  end

  always @(negedge clk) begin
    if (tx_start) begin
      log_q.push_back(tx_data);
      gaps.push_back(cyc - fall_edge);
      if (busy_s) busy_err++;
      if (start_prev) consec_err++;
    end
    start_prev = tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    while (log_q.size() < n && t < 3000) begin
      tick();
      t++;
    end
    check("wait_starts", log_q.size(), n);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (tx_busy && t < 3000) begin
      tick();
      t++;
    end
    check("wait_idle", {31'd0, tx_busy}, 0);
    repeat (3) tick();
  endtask

  task automatic clear_log();
    log_q.delete();
    gaps.delete();
  endtask

  initial begin
    repeat (2) tick();
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_count", count, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    rst_n = 1'b1;

    // single byte: start pulse two cycles after the write
    write(8'hA5);
    check("single_count1", count, 1);
    check("single_nostart", {31'd0, tx_start}, 0);
    tick();
    check("single_start", {31'd0, tx_start}, 1);
    check("single_data", tx_data, 8'hA5);
    check("single_count0", count, 0);
    tick();
    check("single_pulse_end", {31'd0, tx_start}, 0);
    check("single_data_hold", tx_data, 8'hA5);
    begin
      int t = 0;
      while (txd !== 1'b0 && t < 50) begin
        tick();
        t++;
      end
      repeat (BIT / 2) tick();
      for (int i = 0; i < 11; i++) begin
        frame[i] = txd;
        repeat (BIT) tick();
      end
    end
    check("single_frame", frame, {2'b11, 8'hA5, 1'b0});
    wait_idle();
    check("single_nstarts", log_q.size(), 1);

    // burst order and inter-frame gap
    clear_log();
    write(8'h01);
    write(8'h02);
    write(8'h03);
    check("burst_count", count, 2);
    wait_starts(3);
    check("burst_b0", log_q[0], 8'h01);
    check("burst_b1", log_q[1], 8'h02);
    check("burst_b2", log_q[2], 8'h03);
    check("burst_gap1", gaps[1], 1);
    check("burst_gap2", gaps[2], 1);
    wait_idle();

    // full and overflow
    clear_log();
    ext_busy = 1'b1;
    for (int i = 0; i < 16; i++) write(8'(8'h10 + i));
    check("full_flag", {31'd0, full}, 1);
    check("full_count", count, 16);
    check("full_no_ovf", {31'd0, overflow}, 0);
    write(8'h20);
    check("ovf_set", {31'd0, overflow}, 1);
    check("ovf_count", count, 16);
    repeat (5) tick();
    check("ovf_sticky", {31'd0, overflow}, 1);
    check("ovf_no_start", log_q.size(), 0);
    ext_busy = 1'b0;
    wait_starts(16);
    for (int i = 0; i < 16; i++) check("drain_order", log_q[i], 8'(8'h10 + i));
    wait_idle();
    check("drain_total", log_q.size(), 16);
    check("drain_empty", {31'd0, empty}, 1);
    check("drain_ovf", {31'd0, overflow}, 1);

    // simultaneous push and pop
    clear_log();
    ext_busy = 1'b1;
    write(8'h30);
    write(8'h31);
    check("pp_count_pre", count, 2);
    ext_busy = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h32;
    tick();
    wr_en = 1'b0;
    check("pp_count_same", count, 2);
    check("pp_start", {31'd0, tx_start}, 1);
    check("pp_data", tx_data, 8'h30);
    wait_starts(3);
    check("pp_b1", log_q[1], 8'h31);
    check("pp_b2", log_q[2], 8'h32);
    wait_idle();

    // reset during WAIT with bytes queued
    clear_log();
    for (int i = 0; i < 6; i++) write(8'(8'h40 + i));
    repeat (4) tick();
    check("mid_count", count, 5);
    check("mid_first", log_q[0], 8'h40);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_start", {31'd0, tx_start}, 0);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", {31'd0, empty}, 1);
    check("mid_rst_full", {31'd0, full}, 0);
    check("mid_rst_ovf", {31'd0, overflow}, 0);
    wait_idle();
    repeat (10) tick();
    check("mid_discard", log_q.size(), 1);
    write(8'h55);
    wait_starts(2);
    check("mid_new_byte", log_q[1], 8'h55);
    wait_idle();

    // external busy hold
    clear_log();
    ext_busy = 1'b1;
    write(8'h61);
    write(8'h62);
    repeat (100) tick();
    check("ext_no_start", log_q.size(), 0);
    check("ext_count", count, 2);
    ext_busy = 1'b0;
    tick();
    check("ext_start", {31'd0, tx_start}, 1);
    check("ext_data", tx_data, 8'h61);
    wait_starts(2);
    check("ext_gap", gaps[0], 0);
    check("ext_b1", log_q[1], 8'h62);
    wait_idle();

    check("mon_start_while_busy", busy_err, 0);
    check("mon_consecutive_start", consec_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
